// File: rtl/alu_sched_pkg.sv
// ---------------------------------------------------------------------------
// alu_sched_pkg
// Shared definitions for the round-robin ALU scheduler: opcode encodings,
// scheduler FSM state type and the supported requester ceiling.
// Optional feature macro used by this slice: ALU_SCHED_CARRY_EN.
// ---------------------------------------------------------------------------
package alu_sched_pkg;

   localparam int MAX_NREQ = 8;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_SLL   = 4'd4;
   localparam logic [3:0] OP_MIN   = 4'd5;
   localparam logic [3:0] OP_PASSB = 4'd6;
   localparam logic [3:0] OP_MUL   = 4'd7;
   localparam logic [3:0] OP_ROR   = 4'd8;
   localparam logic [3:0] OP_SGT   = 4'd9;
   localparam logic [3:0] OP_XOR   = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sched_state_e;

endpackage

// File: rtl/alu_exec_core.sv
// ---------------------------------------------------------------------------
// alu_exec_core
// Purely combinational ALU shared by all requesters of the scheduler.
// Macro ALU_SCHED_CARRY_EN: when defined, carry_o is the carry (ADD) or
// borrow (SUB) out of the WIDTH-bit operation; when undefined the carry
// extraction is not built and carry_o is constant 0.
// Ports:
//   opcode_i  in  4      operation select (11..15 give result 0)
//   a_i       in  WIDTH  operand 1
//   b_i       in  WIDTH  operand 2
//   shift_i   in  5      shift/rotate amount
//   result_o  out WIDTH  result, modulo 2^WIDTH
//   carry_o   out 1      carry/borrow flag, 0 for all other ops
// ---------------------------------------------------------------------------
module alu_exec_core
   import alu_sched_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [3:0]       opcode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [4:0]       shift_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o
);

   logic [WIDTH-1:0] add_r;
   logic [WIDTH-1:0] sub_r;
   logic [WIDTH-1:0] ror_r;
   logic             add_c;
   logic             sub_c;

`ifdef ALU_SCHED_CARRY_EN
   logic [WIDTH:0] sum_w;
   logic [WIDTH:0] diff_w;

   assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
   assign diff_w = {1'b0, a_i} - {1'b0, b_i};
   assign add_r  = sum_w[WIDTH-1:0];
   assign sub_r  = diff_w[WIDTH-1:0];
   assign add_c  = sum_w[WIDTH];
   assign sub_c  = diff_w[WIDTH];
`else
   assign add_r  = a_i + b_i;
   assign sub_r  = a_i - b_i;
   assign add_c  = 1'b0;
   assign sub_c  = 1'b0;
`endif

   // Rotating the doubled word and keeping the low half gives ROR, and a
   // zero amount naturally returns a unchanged.
   assign ror_r = WIDTH'({a_i, a_i} >> shift_i);

   always_comb begin
      result_o = '0;
      carry_o  = 1'b0;
      case (opcode_i)
         OP_ADD: begin
            result_o = add_r;
            carry_o  = add_c;
         end
         OP_SUB: begin
            result_o = sub_r;
            carry_o  = sub_c;
         end
         OP_AND:   result_o = a_i & b_i;
         OP_OR:    result_o = a_i | b_i;
         OP_SLL:   result_o = a_i << shift_i;
         OP_MIN:   result_o = (a_i < b_i) ? a_i : b_i;
         OP_PASSB: result_o = b_i;
         OP_MUL:   result_o = a_i * b_i;
         OP_ROR:   result_o = ror_r;
         OP_SGT:   result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) > $signed(b_i))};
         OP_XOR:   result_o = a_i ^ b_i;
         default: begin
            result_o = '0;
            carry_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Round-robin arbiter sharing one alu_exec_core among NREQ requesters with a
// single operation in flight; MUL occupies EXEC for MUL_LAT cycles.
// Macro ALU_SCHED_CARRY_EN enables the carry flag (rsp_carry is 0 otherwise).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no op in flight; grant first valid requester at/after rr ptr
//   EXEC  | latched op executing; MUL waits MUL_LAT cycles, others one
//   RESP  | response held on rsp_* until rsp_ready; then advance rr ptr
//
// Ports:
//   clk, rst_n   clock (rising) and async active-low reset
//   req_valid    in  NREQ        per-requester request valid
//   req_ready    out NREQ        combinational grant, one-hot or zero
//   req_opcode   in  NREQ*4      packed opcodes
//   req_a/req_b  in  NREQ*WIDTH  packed operands
//   req_shift    in  NREQ*5      packed shift amounts
//   rsp_valid    out 1           response valid
//   rsp_ready    in  1           response accepted
//   rsp_id       out clog2(NREQ) requester index of the response
//   rsp_result   out WIDTH       result
//   rsp_carry    out 1           carry/borrow flag
//   busy         out 1           high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 64,
   parameter int MUL_LAT = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*4-1:0]        req_opcode,
   input  logic [NREQ*WIDTH-1:0]    req_a,
   input  logic [NREQ*WIDTH-1:0]    req_b,
   input  logic [NREQ*5-1:0]        req_shift,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [WIDTH-1:0]         rsp_result,
   output logic                     rsp_carry,
   output logic                     busy
);

   localparam int IDW   = $clog2(NREQ);
   localparam int CNT_W = 4;

   sched_state_e     state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [4:0]       sh_q, sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] core_res;
   logic             core_carry;

   logic             found;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   cand;
   int               idx;

   alu_exec_core #(.WIDTH(WIDTH)) u_core (
      .opcode_i (op_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .shift_i  (sh_q),
      .result_o (core_res),
      .carry_o  (core_carry)
   );

   // Rotating search starting at the pointer; wraps at NREQ-1 so that
   // non-power-of-two requester counts work.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = IDW'(idx);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      sh_d      = sh_q;
      res_d     = res_q;
      carry_d   = carry_q;
      cnt_d     = cnt_q;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               req_ready[win] = 1'b1;
               id_d           = win;
               cnt_d          = '0;
               state_d        = EXEC;
               for (int k = 0; k < NREQ; k++) begin
                  if (win == IDW'(k)) begin
                     op_d = req_opcode[4*k +: 4];
                     a_d  = req_a[WIDTH*k +: WIDTH];
                     b_d  = req_b[WIDTH*k +: WIDTH];
                     sh_d = req_shift[5*k +: 5];
                  end
               end
            end
         end
         EXEC: begin
            if (op_q != OP_MUL || cnt_q == CNT_W'(MUL_LAT - 1)) begin
               res_d   = core_res;
               carry_d = core_carry;
               cnt_d   = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sh_q    <= sh_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rsp_valid  = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign rsp_id     = id_q;
   assign rsp_result = res_q;
   assign rsp_carry  = carry_q;

endmodule
